rf_wb_sched: RTL and testbench

RF_WB_SCHED -- requirements
Module: rf_wb_sched

---
 rtl/rf_wb_sched.sv | 143 ++++++++++++++
 tb/tb_rf_wb_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: dual-lane register-file writeback scheduler.
// Retiring results go into a circular FIFO. Up to two entries drain per cycle
// into two registered write ports. Writes to the same register in one pair
// are coalesced, and pend_mask shows which registers have writes in flight.
module rf_wb_sched #(
    parameter int OPRAND_WIDTH  = 32,
    parameter int REGNAME_WIDTH = 5,
    parameter int QUEUE_DEPTH   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in1_valid,
    input  logic [REGNAME_WIDTH-1:0]         in1_target,
    input  logic [OPRAND_WIDTH-1:0]          in1_data,
    input  logic                             in2_valid,
    input  logic [REGNAME_WIDTH-1:0]         in2_target,
    input  logic [OPRAND_WIDTH-1:0]          in2_data,
    output logic                             in_ready,
    input  logic                             rf_stall,
    output logic                             WB_en1,
    output logic [REGNAME_WIDTH-1:0]         WB_target1,
    output logic [OPRAND_WIDTH-1:0]          WB_data1,
    output logic                             WB_en2,
    output logic [REGNAME_WIDTH-1:0]         WB_target2,
    output logic [OPRAND_WIDTH-1:0]          WB_data2,
    output logic [2**REGNAME_WIDTH-1:0]      pend_mask,
    output logic [$clog2(QUEUE_DEPTH):0]     q_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    // Queue storage and pointers. The pointers wrap naturally because the depth is a power of two.
    logic [REGNAME_WIDTH-1:0] mem_target [QUEUE_DEPTH];
    logic [OPRAND_WIDTH-1:0]  mem_data   [QUEUE_DEPTH];
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;

    logic          push1;
    logic          push2;
    logic [PW-1:0] wr_ptr2;
    logic [PW-1:0] head_p1;
    logic          pop1;
    logic          pop2;
    logic          same_target;
    logic [CW-1:0] n_push;
    logic [CW-1:0] n_pop;

    // Decide what gets pushed and popped this cycle. Both decisions use the current occupancy.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block can infer a latch.
        push1       = 1'b0;
        push2       = 1'b0;
        pop1        = 1'b0;
        pop2        = 1'b0;
        in_ready    = (q_count <= CW'(QUEUE_DEPTH - 2));
        if (in_ready) begin
            push1 = in1_valid && (in1_target != '0);
            push2 = in2_valid && (in2_target != '0);
        end
        // in2 goes into the slot after in1 only when in1 actually takes a slot.
        wr_ptr2     = push1 ? tail + PW'(1) : tail;
        head_p1     = head + PW'(1);
        if (!rf_stall) begin
            pop2 = (q_count >= CW'(2));
            pop1 = (q_count == CW'(1));
        end
        same_target = (mem_target[head] == mem_target[head_p1]);
        n_push      = CW'(push1) + CW'(push2);
        n_pop       = pop2 ? CW'(2) : CW'(pop1);
    end

    // Queue payload writes. This storage has no reset because q_count decides which slots are valid.
    always_ff @(posedge clk) begin
        // NOTE: the memory is left unreset on purpose, because stale slots are never observed.
        if (push1) begin
            mem_target[tail] <= in1_target;
            mem_data[tail]   <= in1_data;
        end
        if (push2) begin
            mem_target[wr_ptr2] <= in2_target;
            mem_data[wr_ptr2]   <= in2_data;
        end
    end

    // Pointer and occupancy update. Reset takes priority over push, pop and stall.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            q_count <= '0;
        end else begin
            tail    <= tail + PW'(n_push);
            head    <= head + PW'(n_pop);
            q_count <= q_count + n_push - n_pop;
        end
    end

    // Registered write ports. When a popped pair has the same target, only the younger entry is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_en1     <= 1'b0;
            WB_target1 <= '0;
            WB_data1   <= '0;
            WB_en2     <= 1'b0;
            WB_target2 <= '0;
            WB_data2   <= '0;
        end else begin
            WB_en1 <= pop1 || (pop2 && !same_target);
            WB_en2 <= pop2;
            if (pop1 || pop2) begin
                WB_target1 <= mem_target[head];
                WB_data1   <= mem_data[head];
            end
            if (pop2) begin
                WB_target2 <= mem_target[head_p1];
                WB_data2   <= mem_data[head_p1];
            end
        end
    end

    // Pending registers: every occupied queue slot plus both active write ports. Register 0 is never pending.
    always_comb begin : pend_calc
        logic [PW-1:0] off;
        off       = '0;
        pend_mask = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            off = PW'(i) - head;
            if ({1'b0, off} < q_count) begin
                pend_mask[mem_target[i]] = 1'b1;
            end
        end
        if (WB_en1) begin
            pend_mask[WB_target1] = 1'b1;
        end
        if (WB_en2) begin
            pend_mask[WB_target2] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: randomized and directed bench for rf_wb_sched.
// The reference model is a plain queue of results, drained two at a time.
module tb_rf_wb_sched;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NREG  = 2**RW;

    typedef struct {
        logic [RW-1:0] t;
        logic [DW-1:0] d;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in1_valid = 1'b0;
    logic [RW-1:0]   in1_target = '0;
    logic [DW-1:0]   in1_data = '0;
    logic            in2_valid = 1'b0;
    logic [RW-1:0]   in2_target = '0;
    logic [DW-1:0]   in2_data = '0;
    logic            in_ready;
    logic            rf_stall = 1'b0;
    logic            WB_en1;
    logic [RW-1:0]   WB_target1;
    logic [DW-1:0]   WB_data1;
    logic            WB_en2;
    logic [RW-1:0]   WB_target2;
    logic [DW-1:0]   WB_data2;
    logic [NREG-1:0] pend_mask;
    logic [CW-1:0]   q_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    ent_t          mq[$];
    logic          exp_en1, exp_en2;
    logic [RW-1:0] exp_t1, exp_t2;
    logic [DW-1:0] exp_d1, exp_d2;

    rf_wb_sched #(.OPRAND_WIDTH(DW), .REGNAME_WIDTH(RW), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in1_target(in1_target), .in1_data(in1_data),
        .in2_valid(in2_valid), .in2_target(in2_target), .in2_data(in2_data),
        .in_ready(in_ready), .rf_stall(rf_stall),
        .WB_en1(WB_en1), .WB_target1(WB_target1), .WB_data1(WB_data1),
        .WB_en2(WB_en2), .WB_target2(WB_target2), .WB_data2(WB_data2),
        .pend_mask(pend_mask), .q_count(q_count)
    );

    always #5 clk = ~clk;

    // Set of registers that still have a write in flight, according to the model.
    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].t] = 1'b1;
        if (exp_en1) m[exp_t1] = 1'b1;
        if (exp_en2) m[exp_t2] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Drive one cycle of inputs and advance the model across the edge. Returns at the next negedge.
    task automatic drive_cycle(input logic v1, input logic [RW-1:0] t1, input logic [DW-1:0] d1,
                               input logic v2, input logic [RW-1:0] t2, input logic [DW-1:0] d2,
                               input logic stall);
        ent_t a, b;
        int   npop;
        bit   ready;
        in1_valid = v1; in1_target = t1; in1_data = d1;
        in2_valid = v2; in2_target = t2; in2_data = d2;
        rf_stall  = stall;
        ready = (DEPTH - mq.size()) >= 2;
        npop  = stall ? 0 : ((mq.size() >= 2) ? 2 : mq.size());
        exp_en1 = 1'b0;
        exp_en2 = 1'b0;
        if (npop == 2) begin
            a = mq.pop_front();
            b = mq.pop_front();
            exp_en2 = 1'b1; exp_t2 = b.t; exp_d2 = b.d;
            if (a.t != b.t) begin
                exp_en1 = 1'b1; exp_t1 = a.t; exp_d1 = a.d;
            end
        end else if (npop == 1) begin
            a = mq.pop_front();
            exp_en1 = 1'b1; exp_t1 = a.t; exp_d1 = a.d;
        end
        if (ready) begin
            if (v1 && t1 != '0) mq.push_back('{t: t1, d: d1});
            if (v2 && t2 != '0) mq.push_back('{t: t2, d: d2});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle(input logic stall);
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, stall);
    endtask

    // Hold reset for one edge while the inputs still present valid lanes, then clear the model.
    task automatic do_reset();
        rst = 1'b1;
        in1_valid = 1'b1; in1_target = 5'd4;  in1_data = 32'hDEAD0004;
        in2_valid = 1'b1; in2_target = 5'd6;  in2_data = 32'hDEAD0006;
        rf_stall  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in1_valid = 1'b0; in2_valid = 1'b0;
        mq.delete();
        exp_en1 = 1'b0; exp_en2 = 1'b0;
        exp_t1 = '0; exp_t2 = '0; exp_d1 = '0; exp_d2 = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (WB_en1 !== 1'b0 || WB_en2 !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b%b expected 00", WB_en1, WB_en2); end
        n_checks++; if (WB_target1 !== '0 || WB_target2 !== '0) begin n_fail++; $display("FAIL reset_target: got %0d/%0d expected 0/0", WB_target1, WB_target2); end
        n_checks++; if (WB_data1 !== '0 || WB_data2 !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", WB_data1, WB_data2); end
        n_checks++; if (q_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", q_count); end
        n_checks++; if (pend_mask !== '0) begin n_fail++; $display("FAIL reset_pend: got %h expected 0", pend_mask); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_write();
        drive_cycle(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, '0, '0, 1'b0);
        n_checks++; if (pend_mask[5] !== 1'b1) begin n_fail++; $display("FAIL single_pend_q: got %b expected 1", pend_mask[5]); end
        n_checks++; if (WB_en1 !== 1'b0) begin n_fail++; $display("FAIL single_early: got WB_en1=%b expected 0", WB_en1); end
        idle_cycle(1'b0);
        n_checks++; if (WB_en1 !== 1'b1 || WB_target1 !== 5'd5 || WB_data1 !== 32'hA5A5A5A5)
            begin n_fail++; $display("FAIL single_wb1: got en=%b t=%0d d=%h expected en=1 t=5 d=a5a5a5a5", WB_en1, WB_target1, WB_data1); end
        n_checks++; if (WB_en2 !== 1'b0) begin n_fail++; $display("FAIL single_wb2: got %b expected 0", WB_en2); end
        n_checks++; if (pend_mask[5] !== 1'b1) begin n_fail++; $display("FAIL single_pend_wb: got %b expected 1", pend_mask[5]); end
        idle_cycle(1'b0);
        n_checks++; if (pend_mask !== '0 || WB_en1 !== 1'b0) begin n_fail++; $display("FAIL single_done: got pend=%h en1=%b expected 0/0", pend_mask, WB_en1); end
    endtask

    task automatic test_coalesce();
        drive_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0);
        idle_cycle(1'b0);
        n_checks++; if (WB_en1 !== 1'b0) begin n_fail++; $display("FAIL coalesce_en1: got %b expected 0", WB_en1); end
        n_checks++; if (WB_en2 !== 1'b1 || WB_target2 !== 5'd3 || WB_data2 !== 32'h22)
            begin n_fail++; $display("FAIL coalesce_wb2: got en=%b t=%0d d=%h expected en=1 t=3 d=22", WB_en2, WB_target2, WB_data2); end
        idle_cycle(1'b0);
    endtask

    task automatic test_full_backpressure();
        for (int p = 0; p < 4; p++) begin
            drive_cycle(1'b1, RW'(2*p+1), DW'(32'h100 + 2*p+1), 1'b1, RW'(2*p+2), DW'(32'h100 + 2*p+2), 1'b1);
        end
        n_checks++; if (q_count !== CW'(8)) begin n_fail++; $display("FAIL full_count: got %0d expected 8", q_count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", in_ready); end
        // Held inputs while full must not be taken.
        for (int k = 0; k < 2; k++) drive_cycle(1'b1, 5'd9, 32'h109, 1'b1, 5'd10, 32'h10A, 1'b1);
        n_checks++; if (q_count !== CW'(8)) begin n_fail++; $display("FAIL full_hold: got %0d expected 8", q_count); end
        for (int p = 0; p < 4; p++) begin
            idle_cycle(1'b0);
            n_checks++;
            if (WB_en1 !== 1'b1 || WB_target1 !== RW'(2*p+1) || WB_data1 !== DW'(32'h100 + 2*p+1) ||
                WB_en2 !== 1'b1 || WB_target2 !== RW'(2*p+2) || WB_data2 !== DW'(32'h100 + 2*p+2))
                begin n_fail++; $display("FAIL drain_pair%0d: got %b:%0d:%h %b:%0d:%h expected 1:%0d 1:%0d",
                                         p, WB_en1, WB_target1, WB_data1, WB_en2, WB_target2, WB_data2, 2*p+1, 2*p+2); end
        end
        idle_cycle(1'b0);
        n_checks++; if (q_count !== '0 || WB_en1 !== 1'b0 || WB_en2 !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got cnt=%0d en=%b%b expected 0/00", q_count, WB_en1, WB_en2); end
    endtask

    task automatic test_target0();
        drive_cycle(1'b1, 5'd0, 32'hFF, 1'b1, 5'd9, 32'h99, 1'b0);
        n_checks++; if (q_count !== CW'(1)) begin n_fail++; $display("FAIL t0_count: got %0d expected 1", q_count); end
        idle_cycle(1'b0);
        n_checks++; if (WB_en1 !== 1'b1 || WB_target1 !== 5'd9 || WB_data1 !== 32'h99 || WB_en2 !== 1'b0)
            begin n_fail++; $display("FAIL t0_wb: got en1=%b t=%0d d=%h en2=%b expected 1 9 99 0", WB_en1, WB_target1, WB_data1, WB_en2); end
        idle_cycle(1'b0);
    endtask

    // Mixed random traffic, well past pointer wraparound, compared to the model every cycle.
    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive_cycle($urandom_range(0, 3) != 0, RW'($urandom_range(0, 7)), $urandom,
                        $urandom_range(0, 3) != 0, RW'($urandom_range(0, 7)), $urandom,
                        $urandom_range(0, 9) < 4);
            n_checks++; if (WB_en1 !== exp_en1 || WB_en2 !== exp_en2) begin n_fail++; $display("FAIL rand_en c=%0d: got %b%b expected %b%b", c, WB_en1, WB_en2, exp_en1, exp_en2); end
            if (exp_en1) begin
                n_checks++; if (WB_target1 !== exp_t1 || WB_data1 !== exp_d1) begin n_fail++; $display("FAIL rand_p1 c=%0d: got %0d:%h expected %0d:%h", c, WB_target1, WB_data1, exp_t1, exp_d1); end
            end
            if (exp_en2) begin
                n_checks++; if (WB_target2 !== exp_t2 || WB_data2 !== exp_d2) begin n_fail++; $display("FAIL rand_p2 c=%0d: got %0d:%h expected %0d:%h", c, WB_target2, WB_data2, exp_t2, exp_d2); end
            end
            n_checks++; if (q_count !== CW'(mq.size())) begin n_fail++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, q_count, mq.size()); end
            n_checks++; if (in_ready !== ((DEPTH - mq.size()) >= 2)) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b", c, in_ready); end
            n_checks++; if (pend_mask !== model_mask()) begin n_fail++; $display("FAIL rand_pend c=%0d: got %h expected %h", c, pend_mask, model_mask()); end
        end
        for (int c = 0; c < 6; c++) idle_cycle(1'b0);
        n_checks++; if (q_count !== '0 || pend_mask !== '0) begin n_fail++; $display("FAIL rand_drain: got cnt=%0d pend=%h expected 0/0", q_count, pend_mask); end
    endtask

    task automatic test_reset_midflight();
        drive_cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1);
        drive_cycle(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 1'b1);
        drive_cycle(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'h0, 1'b1);
        n_checks++; if (q_count !== CW'(5)) begin n_fail++; $display("FAIL mid_fill: got %0d expected 5", q_count); end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (WB_en1 !== 1'b0 || WB_en2 !== 1'b0 || q_count !== '0 || pend_mask !== '0 || in_ready !== 1'b1)
                begin n_fail++; $display("FAIL mid_reset c=%0d: got en=%b%b cnt=%0d pend=%h rdy=%b expected 00 0 0 1",
                                         c, WB_en1, WB_en2, q_count, pend_mask, in_ready); end
            idle_cycle(1'b0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_write();
        test_coalesce();
        test_full_backpressure();
        test_target0();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
